data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//   Data-memory responder at the far end of the MEM-stage memory access interface.
//   Accepts load/store requests from the MEM stage and executes them against an internal word array.
//   Stalls the pipeline with Busy for a configurable access latency.
//   Returns sign/zero-extended load data that the MEM/WB register captures as Memory_Data.
//   Covers all RV32IM byte, half and word loads and stores.
// PARAMETERS
//   ADDR_BITS  10  word-index width; array holds 2**ADDR_BITS 32-bit words
//   LATENCY    2   cycles in ACCESS state per request; legal range 1..15
// PORTS
//   CLK         in   1   clock; all state updates on rising edge
//   Reset       in   1   asynchronous reset, active-low
//   Mem_Read    in   1   load request from MEM stage
//   Mem_Write   in   1   store request from MEM stage
//   Funct3      in   3   RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   Address     in   32  byte address from ALU_Output
//   Write_Data  in   32  store data (rs2); low byte/half used for SB/SH
//   Read_Data   out  32  extended load result, becomes Memory_Data at MEM/WB
//   Busy        out  1   stall request to pipeline; MEM/EX registers hold while 1
//   Misaligned  out  1   one-cycle pulse: request was misaligned, no access done
// BEHAVIOUR
//   Reset (Reset=0, async): state=IDLE, counter=0; Read_Data=0, Busy=0, Misaligned=0.
//     Reset does not clear the array. A store that is in flight is aborted and leaves memory unchanged.
//   FSM states IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE: a request is Mem_Read|Mem_Write. On a request, latch Address, Funct3, Write_Data and the op.
//     Load counter=LATENCY-1 and go to ACCESS.
//     Busy=1 combinationally in the request cycle, so the pipeline freezes immediately.
//   ACCESS: Busy=1; counter decrements each cycle. When counter==0, perform the access and go to DONE.
//     Requesting inputs are ignored; all work uses the latched copies.
//   DONE: Busy=0 for exactly one cycle. Read_Data and Misaligned are valid, and the pipeline advances.
//     Always return to IDLE; a new request is sampled only in IDLE.
//   Request-to-DONE latency = LATENCY+1 cycles; Busy is high for LATENCY+1 cycles per request.
//   Read_Data is registered; it holds its value in IDLE/ACCESS until the next DONE updates it.
//   Word index = Address[ADDR_BITS+1:2]. Higher address bits are ignored, so the array wraps (aliases).
//   Loads: select the lane from Address[1:0].
//     B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
//   Stores use byte-lane write enables: SB writes 1 lane, SH writes 2 lanes, SW writes all 4.
//     Unwritten lanes are preserved.
//   Misalignment: H/HU/SH with Address[0]=1, or W/SW with Address[1:0]!=0.
//     Result: no array write, Read_Data=0, Misaligned=1 in DONE only.
//   Mem_Read and Mem_Write both 1: treated as a store; Read_Data=0 in DONE.
//   Illegal Funct3 (011, 110, 111): no access, Read_Data=0, Misaligned=0, normal DONE timing.
// TESTING
//   Reset=0 mid-ACCESS of SW 0xDEADBEEF to 0x10 -> Busy=0 and Read_Data=0 at once.
//     A later LW 0x10 returns the old contents.
//   SW 0xA5A5A5A5 @0x20, then LW @0x20 -> Busy high 3 cycles (LATENCY=2); Read_Data=0xA5A5A5A5 in DONE.
//   SB 0x80 @0x21, then LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080.
//     LW @0x20 -> 0xA5A580A5.
//   SH 0x8001 @0x32, then LH @0x32 -> 0xFFFF8001; LHU @0x32 -> 0x00008001.
//     Low half of word 0x30 is unchanged.
//   LW @0x22 -> Misaligned=1 for one cycle, Read_Data=0; SH @0x31 -> memory unchanged.
//   SW 0x12345678 @ (0x40 + 4*2**ADDR_BITS), then LW @0x40 -> 0x12345678 (wrap/alias).
//     Back-to-back requests -> each DONE is followed by a new Busy in the next IDLE cycle.

Source files
------------

// File: rtl/data_memory_responder.sv
// Data-memory responder: executes MEM-stage loads/stores against an internal word array.
// Busy stalls the pipeline for LATENCY+1 cycles per request; results are registered in DONE.
module data_memory_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Mem_Read,
  input  logic        Mem_Write,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Address,
  input  logic [31:0] Write_Data,
  output logic [31:0] Read_Data,
  output logic        Busy,
  output logic        Misaligned
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [ADDR_BITS+1:0]  r_addr;
  logic [31:0]           r_wdata;
  logic [2:0]            r_f3;
  logic                  r_store;
  logic [31:0]           r_rdata;
  logic                  r_mis;
  logic [31:0]           r_mem [0:(1<<ADDR_BITS)-1];

  logic                  w_req;
  logic                  w_fire;
  logic [ADDR_BITS-1:0]  w_idx;
  logic [31:0]           w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic                  w_illegal;
  logic                  w_mis;
  logic                  w_ok;
  logic [31:0]           w_ext;
  logic [31:0]           w_load_val;
  logic [3:0]            w_be;
  logic [31:0]           w_wlane;
  logic                  w_we;
  logic                  w_unused;

  // Upper address bits only alias the array.
  assign w_unused = ^Address[31:ADDR_BITS+2];

  assign w_req     = Mem_Read | Mem_Write;
  assign w_fire    = (r_state == S_ACCESS) && (r_cnt == 4'd0);
  assign w_idx     = r_addr[ADDR_BITS+1:2];
  assign w_word    = r_mem[w_idx];
  assign w_half    = r_addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_illegal = (r_f3 == 3'b011) || (r_f3[2:1] == 2'b11) || (r_store && r_f3[2]);
  assign w_mis     = !w_illegal &&
                     (((r_f3[1:0] == 2'b01) && r_addr[0]) ||
                      ((r_f3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00)));
  assign w_ok      = !w_illegal && !w_mis;
  assign w_we      = w_fire && r_store && w_ok;
  assign w_load_val = (!r_store && w_ok) ? w_ext : 32'd0;

  always_comb begin
    w_byte = w_word[7:0];
    case (r_addr[1:0])
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      2'd3:    w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
  end

  always_comb begin
    w_ext = 32'd0;
    case (r_f3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b010:  w_ext = w_word;
      3'b100:  w_ext = {24'd0, w_byte};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = 32'd0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    w_be    = 4'b0000;
    w_wlane = r_wdata;
    case (r_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wlane = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << r_addr[1:0];
        w_wlane = {2{r_wdata[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wlane = r_wdata;
      end
      default: begin
        w_be    = 4'b0000;
        w_wlane = r_wdata;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    Busy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        Busy = w_req;
        if (w_req) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        Busy = 1'b1;
        if (r_cnt == 4'd0) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (!Reset) Busy = 1'b0;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_f3    <= 3'd0;
      r_store <= 1'b0;
      r_rdata <= 32'd0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_mis   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr  <= Address[ADDR_BITS+1:0];
            r_wdata <= Write_Data;
            r_f3    <= Funct3;
            r_store <= Mem_Write;
            r_cnt   <= 4'(LATENCY - 1);
          end
        end
        S_ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rdata <= w_load_val;
            r_mis   <= w_mis;
          end
        end
        default: ;
      endcase
    end
  end

  // Array is deliberately outside reset; an aborted store never reaches w_we.
  always_ff @(posedge CLK) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
      end
    end
  end

  assign Read_Data  = r_rdata;
  assign Misaligned = r_mis;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboarded bench: byte-array reference model, monitor checks every DONE cycle.
module tb_data_memory_responder;
  localparam int AB  = 10;
  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Mem_Read = 1'b0;
  logic        Mem_Write = 1'b0;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] Address = 32'd0;
  logic [31:0] Write_Data = 32'd0;
  logic [31:0] Read_Data;
  logic        Busy;
  logic        Misaligned;

  data_memory_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .CLK(CLK), .Reset(Reset), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Funct3(Funct3), .Address(Address), .Write_Data(Write_Data),
    .Read_Data(Read_Data), .Busy(Busy), .Misaligned(Misaligned)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  int          busy_run = 0;
  logic        prev_busy = 1'b0;
  exp_t        q[$];
  logic [7:0]  mbytes [0:(4<<AB)-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: little-endian byte memory, byte address modulo array size.
  function automatic exp_t model(input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int          base;
    int          size;
    bit          illegal;
    bit          mis;
    logic [31:0] v;
    base    = int'(a[AB+1:0]);
    size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || (wr && f3[2]);
    mis     = !illegal && ((base % size) != 0);
    e.rd    = 32'd0;
    e.mis   = mis;
    if (wr) begin
      if (!illegal && !mis)
        for (int k = 0; k < size; k++) mbytes[base + k] = wd[8*k +: 8];
    end else if (!illegal && !mis) begin
      v = 32'd0;
      for (int k = 0; k < size; k++) v = v | (32'(mbytes[base + k]) << (8*k));
      if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
      if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
      e.rd = v;
    end
    return e;
  endfunction

  always @(negedge CLK) begin
    if (!Reset) begin
      prev_busy = 1'b0;
      busy_run  = 0;
    end else begin
      if (Busy) busy_run++;
      if (prev_busy && !Busy) begin
        exp_t e;
        done_cnt++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got DONE expected none at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("read_data", Read_Data, e.rd);
          chk("misaligned_done", 32'(Misaligned), 32'(e.mis));
          chk("busy_cycles", 32'(busy_run), 32'(LAT + 1));
        end
        busy_run = 0;
      end else begin
        chk("misaligned_quiet", 32'(Misaligned), 32'd0);
      end
      prev_busy = Busy;
    end
  end

  // Called just after a rising edge with the DUT idle; returns the same way.
  task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    int start;
    bit got;
    start = done_cnt;
    got   = 1'b0;
    Mem_Read = rd; Mem_Write = wr; Funct3 = f3; Address = a; Write_Data = wd;
    q.push_back(model(wr, f3, a, wd));
    @(negedge CLK);
    chk("busy_on_request", 32'(Busy), 32'd1);
    @(posedge CLK); #1;
    Mem_Read = 1'b0; Mem_Write = 1'b0;
    Funct3 = 3'($urandom); Address = $urandom; Write_Data = $urandom;
    for (int n = 0; n < 40 && !got; n++) begin
      @(posedge CLK); #1;
      if (done_cnt != start) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout: got no DONE expected DONE within 40 cycles");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] low30;
    #2 Reset = 1'b0;
    #1;
    chk("reset_read_data", Read_Data, 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_misaligned", 32'(Misaligned), 32'd0);
    @(posedge CLK); @(posedge CLK); #1;
    Reset = 1'b1;

    for (int w = 0; w < 64; w++) do_req(1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom);

    do_req(1'b0, 1'b1, 3'b010, 32'h20, 32'hA5A5A5A5);
    chk("sw_stores_zero", Read_Data, 32'd0);
    do_req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    chk("lw_20", Read_Data, 32'hA5A5A5A5);
    do_req(1'b0, 1'b1, 3'b000, 32'h21, 32'h80);
    do_req(1'b1, 1'b0, 3'b000, 32'h21, 32'h0);
    chk("lb_21", Read_Data, 32'hFFFFFF80);
    do_req(1'b1, 1'b0, 3'b100, 32'h21, 32'h0);
    chk("lbu_21", Read_Data, 32'h00000080);
    do_req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    chk("lw_20_after_sb", Read_Data, 32'hA5A580A5);

    low30 = {mbytes[32'h31], mbytes[32'h30]};
    do_req(1'b0, 1'b1, 3'b001, 32'h32, 32'h8001);
    do_req(1'b1, 1'b0, 3'b001, 32'h32, 32'h0);
    chk("lh_32", Read_Data, 32'hFFFF8001);
    do_req(1'b1, 1'b0, 3'b101, 32'h32, 32'h0);
    chk("lhu_32", Read_Data, 32'h00008001);
    do_req(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
    chk("lw_30_low_kept", Read_Data, {16'h8001, low30});

    do_req(1'b1, 1'b0, 3'b010, 32'h22, 32'h0);
    chk("lw_22_misaligned_zero", Read_Data, 32'd0);
    do_req(1'b0, 1'b1, 3'b001, 32'h31, 32'hFFFF);
    do_req(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
    chk("sh_31_no_write", Read_Data, {16'h8001, low30});

    do_req(1'b1, 1'b0, 3'b011, 32'h20, 32'h0);
    chk("illegal_f3_zero", Read_Data, 32'd0);
    do_req(1'b1, 1'b1, 3'b010, 32'h24, 32'hCAFEF00D);
    chk("rd_wr_both_zero", Read_Data, 32'd0);
    do_req(1'b1, 1'b0, 3'b010, 32'h24, 32'h0);
    chk("lw_24_after_both", Read_Data, 32'hCAFEF00D);

    do_req(1'b0, 1'b1, 3'b010, 32'h40 + (32'd4 << AB), 32'h12345678);
    do_req(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    chk("alias_lw_40", Read_Data, 32'h12345678);

    // Abort a store mid-access with reset; the word must keep its old value.
    do_req(1'b0, 1'b1, 3'b010, 32'h10, 32'h11111111);
    do_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    Mem_Write = 1'b1; Funct3 = 3'b010; Address = 32'h10; Write_Data = 32'hDEADBEEF;
    @(posedge CLK); #1;
    Mem_Write = 1'b0;
    Reset = 1'b0;
    #1;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_read_data", Read_Data, 32'd0);
    @(posedge CLK); @(posedge CLK); #1;
    Reset = 1'b1;
    do_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_10_after_abort", Read_Data, 32'h11111111);

    for (int i = 0; i < 300; i++) begin
      logic        wr;
      logic        rd;
      logic [2:0]  f3;
      logic [31:0] a;
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      f3 = 3'($urandom_range(0, 7));
      if (wr && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
      a  = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 255));
      do_req(rd, wr, f3, a, $urandom);
    end

    repeat (3) @(posedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
